// File: rtl/rr_mux_4way_chip.sv
// Four-source valid/ready merger: round-robin grant into one registered output stage.
// out_sel carries the source index so a downstream demux can re-split the stream.
module rr_mux_4way_chip #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1_data,
  input  logic [WIDTH-1:0] in2_data,
  input  logic [WIDTH-1:0] in3_data,
  input  logic [WIDTH-1:0] in4_data,
  input  logic             in1_valid,
  input  logic             in2_valid,
  input  logic             in3_valid,
  input  logic             in4_valid,
  output logic             in1_ready,
  output logic             in2_ready,
  output logic             in3_ready,
  output logic             in4_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [3:0]            vld;
  logic [3:0]            gnt;
  logic [3:0][WIDTH-1:0] dat;
  logic [1:0]            ptr;
  logic [1:0]            gidx;
  logic [1:0]            idx;
  logic                  hit;
  logic                  free;

  assign vld  = {in4_valid, in3_valid, in2_valid, in1_valid};
  assign dat  = {in4_data, in3_data, in2_data, in1_data};
  assign {in4_ready, in3_ready, in2_ready, in1_ready} = gnt;

  // The slot may be refilled in the same cycle it drains.
  assign free = !out_valid || out_ready;

  // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4); first valid source wins.
  always_comb begin
    gnt  = '0;
    gidx = ptr;
    hit  = 1'b0;
    idx  = '0;
    if (free && !reset) begin
      for (int i = 0; i < 4; i++) begin
        idx = ptr + 2'(i);
        if (!hit && vld[idx]) begin
          hit       = 1'b1;
          gidx      = idx;
          gnt[idx]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'b00;
      ptr       <= 2'b00;
    end else if (hit) begin
      out_valid <= 1'b1;
      out_data  <= dat[gidx];
      out_sel   <= gidx;
      ptr       <= gidx + 2'd1;
    end else if (out_ready) begin
      // Drain without refill: data and tag keep their last value.
      out_valid <= 1'b0;
    end
  end

endmodule
